// File: rtl/mem_2r1w_arb.sv
// Arbiter and sequencer in front of a two-read/one-write synchronous memory: writes have priority
// with a bounded reader starvation guard, reads are granted two per cycle round-robin.
module mem_2r1w_arb #(
    parameter int unsigned width_p      = 32,
    parameter int unsigned els_p        = 16,
    parameter int unsigned num_rd_p     = 4,
    parameter int unsigned max_starve_p = 4,
    localparam int unsigned addr_width_lp = $clog2(els_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,

    input  logic [num_rd_p-1:0]               rd_v_i,
    input  logic [num_rd_p*addr_width_lp-1:0] rd_addr_i,
    output logic [num_rd_p-1:0]               rd_yumi_o,
    output logic [num_rd_p-1:0]               rd_v_o,
    output logic [num_rd_p*width_p-1:0]       rd_data_o,

    input  logic                              wr_v_i,
    input  logic [addr_width_lp-1:0]          wr_addr_i,
    input  logic [width_p-1:0]                wr_data_i,
    output logic                              wr_yumi_o,

    output logic                              mem_a_v_o,
    output logic                              mem_a_w_o,
    output logic [addr_width_lp-1:0]          mem_a_addr_o,
    output logic [width_p-1:0]                mem_a_data_o,
    output logic                              mem_b_v_o,
    output logic [addr_width_lp-1:0]          mem_b_addr_o,
    input  logic [width_p-1:0]                mem_a_data_i,
    input  logic [width_p-1:0]                mem_b_data_i
);

    localparam int unsigned ptr_width_lp = $clog2(num_rd_p);
    localparam int unsigned cnt_width_lp = $clog2(max_starve_p + 1);
    localparam logic [cnt_width_lp-1:0] starve_max_lp = cnt_width_lp'(max_starve_p);

    // Cyclic requester index: (base + off) mod num_rd_p, with off < num_rd_p.
    function automatic logic [ptr_width_lp-1:0] wrap_idx(input logic [ptr_width_lp-1:0] base,
                                                        input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= num_rd_p) begin
            sum = sum - num_rd_p;
        end
        return ptr_width_lp'(sum);
    endfunction

    logic [addr_width_lp-1:0] rd_addr [num_rd_p];
    logic [width_p-1:0]       rd_data [num_rd_p];

    for (genvar k = 0; k < num_rd_p; k++) begin : g_slice
        assign rd_addr[k] = rd_addr_i[k*addr_width_lp +: addr_width_lp];
        assign rd_data_o[k*width_p +: width_p] = rd_data[k];
    end

    logic [ptr_width_lp-1:0] rr_ptr_q, rr_ptr_d;
    logic [cnt_width_lp-1:0] starve_cnt_q, starve_cnt_d;
    logic [ptr_width_lp-1:0] a_owner_q, a_owner_d, b_owner_q, b_owner_d;
    logic                    a_live_q, a_live_d, b_live_q, b_live_d;

    logic                    any_rd;
    logic                    starve_limit;
    logic                    wr_grant;
    logic                    a_found, b_found;
    logic [ptr_width_lp-1:0] a_idx, b_idx;
    logic                    a_grant, b_grant;

    assign any_rd       = |rd_v_i;
    assign starve_limit = (starve_cnt_q == starve_max_lp);
    // A pending reader that has waited out the guard takes the cycle from the writer.
    assign wr_grant     = ~reset_i & wr_v_i & ~(any_rd & starve_limit);

    always_comb begin
        a_found = 1'b0;
        b_found = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        for (int unsigned i = 0; i < num_rd_p; i++) begin
            if (rd_v_i[wrap_idx(rr_ptr_q, i)]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = wrap_idx(rr_ptr_q, i);
                end else if (!b_found) begin
                    b_found = 1'b1;
                    b_idx   = wrap_idx(rr_ptr_q, i);
                end
            end
        end
    end

    assign a_grant = ~reset_i & ~wr_grant & a_found;
    assign b_grant = ~reset_i & ~wr_grant & b_found;

    always_comb begin
        rd_yumi_o = '0;
        if (a_grant) begin
            rd_yumi_o[a_idx] = 1'b1;
        end
        if (b_grant) begin
            rd_yumi_o[b_idx] = 1'b1;
        end
    end

    assign wr_yumi_o    = wr_grant;
    assign mem_a_v_o    = wr_grant | a_grant;
    assign mem_a_w_o    = wr_grant;
    assign mem_a_addr_o = wr_grant ? wr_addr_i : rd_addr[a_idx];
    assign mem_a_data_o = wr_data_i;
    // Port b is only ever driven by the second read grant, never alongside a write.
    assign mem_b_v_o    = b_grant;
    assign mem_b_addr_o = rd_addr[b_idx];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (b_grant) begin
            rr_ptr_d = wrap_idx(b_idx, 1);
        end else if (a_grant) begin
            rr_ptr_d = wrap_idx(a_idx, 1);
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (a_grant || !any_rd) begin
            starve_cnt_d = '0;
        end else if (wr_grant && !starve_limit) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_comb begin
        a_live_d  = a_grant;
        b_live_d  = b_grant;
        a_owner_d = a_grant ? a_idx : a_owner_q;
        b_owner_d = b_grant ? b_idx : b_owner_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_q     <= '0;
            starve_cnt_q <= '0;
            a_owner_q    <= '0;
            b_owner_q    <= '0;
            a_live_q     <= 1'b0;
            b_live_q     <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            a_owner_q    <= a_owner_d;
            b_owner_q    <= b_owner_d;
            a_live_q     <= a_live_d;
            b_live_q     <= b_live_d;
        end
    end

    always_comb begin
        rd_v_o = '0;
        for (int unsigned k = 0; k < num_rd_p; k++) begin
            rd_data[k] = '0;
        end
        if (a_live_q) begin
            rd_data[a_owner_q] = mem_a_data_i;
        end
        if (b_live_q) begin
            rd_data[b_owner_q] = mem_b_data_i;
        end
        if (!reset_i) begin
            if (a_live_q) begin
                rd_v_o[a_owner_q] = 1'b1;
            end
            if (b_live_q) begin
                rd_v_o[b_owner_q] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_2r1w_arb.sv
// Bench for mem_2r1w_arb: a synchronous memory stand-in, a spec-level arbitration model checked
// every cycle, and directed scenarios with literal expectations.
module tb_mem_2r1w_arb;

    localparam int W    = 32;
    localparam int E    = 16;
    localparam int N    = 4;
    localparam int MAXS = 4;
    localparam int AW   = 4;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [N-1:0]    rd_v_i;
    logic [N*AW-1:0] rd_addr_i;
    logic [N-1:0]    rd_yumi_o, rd_v_o;
    logic [N*W-1:0]  rd_data_o;
    logic            wr_v_i;
    logic [AW-1:0]   wr_addr_i;
    logic [W-1:0]    wr_data_i;
    logic            wr_yumi_o;
    logic            mem_a_v_o, mem_a_w_o, mem_b_v_o;
    logic [AW-1:0]   mem_a_addr_o, mem_b_addr_o;
    logic [W-1:0]    mem_a_data_o;
    logic [W-1:0]    mem_a_data_i, mem_b_data_i;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_2r1w_arb #(
        .width_p      (W),
        .els_p        (E),
        .num_rd_p     (N),
        .max_starve_p (MAXS)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .rd_v_i       (rd_v_i),
        .rd_addr_i    (rd_addr_i),
        .rd_yumi_o    (rd_yumi_o),
        .rd_v_o       (rd_v_o),
        .rd_data_o    (rd_data_o),
        .wr_v_i       (wr_v_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .wr_yumi_o    (wr_yumi_o),
        .mem_a_v_o    (mem_a_v_o),
        .mem_a_w_o    (mem_a_w_o),
        .mem_a_addr_o (mem_a_addr_o),
        .mem_a_data_o (mem_a_data_o),
        .mem_b_v_o    (mem_b_v_o),
        .mem_b_addr_o (mem_b_addr_o),
        .mem_a_data_i (mem_a_data_i),
        .mem_b_data_i (mem_b_data_i)
    );

    // Stand-in for the synchronous two-read/one-write memory.
    logic [W-1:0] env_mem [E];
    always @(posedge clk) begin
        if (mem_a_v_o && mem_a_w_o) env_mem[mem_a_addr_o] <= mem_a_data_o;
        else if (mem_a_v_o) mem_a_data_i <= env_mem[mem_a_addr_o];
        if (mem_b_v_o) mem_b_data_i <= env_mem[mem_b_addr_o];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] dslice(input int k);
        return rd_data_o[k*W +: W];
    endfunction

    function automatic logic [AW-1:0] aslice(input int k);
        return rd_addr_i[k*AW +: AW];
    endfunction

    // Spec-level model: pointer, starvation count, expected memory contents, pending responses.
    int           m_rr = 0;
    int           m_starve = 0;
    logic [W-1:0] m_mem [E];
    bit           m_known [E];
    logic [N-1:0] m_pv = '0;
    logic [W-1:0] m_pd [N];
    bit           m_pk [N];
    bit           any_rd, e_wr;
    int           e_a, e_b, cand;
    logic [N-1:0] e_yumi, e_rdv;

    initial begin
        for (int i = 0; i < E; i++) m_known[i] = 1'b0;
        for (int i = 0; i < N; i++) m_pk[i] = 1'b0;
    end

    always begin
        @(negedge clk);
        any_rd = |rd_v_i;
        e_wr   = !reset_i && wr_v_i && !(any_rd && m_starve == MAXS);
        e_a    = -1;
        e_b    = -1;
        e_yumi = '0;
        if (!reset_i && !e_wr) begin
            for (int i = 0; i < N; i++) begin
                cand = (m_rr + i) % N;
                if (rd_v_i[cand]) begin
                    if (e_a < 0) e_a = cand;
                    else if (e_b < 0) e_b = cand;
                end
            end
        end
        if (e_a >= 0) e_yumi[e_a] = 1'b1;
        if (e_b >= 0) e_yumi[e_b] = 1'b1;
        e_rdv = reset_i ? '0 : m_pv;

        chk("m_rd_yumi", 32'(rd_yumi_o), 32'(e_yumi));
        chk("m_wr_yumi", 32'(wr_yumi_o), 32'(e_wr));
        chk("m_mem_a_v", 32'(mem_a_v_o), 32'(e_wr || e_a >= 0));
        chk("m_mem_a_w", 32'(mem_a_w_o), 32'(e_wr));
        chk("m_mem_b_v", 32'(mem_b_v_o), 32'(e_b >= 0));
        chk("m_no_wr_and_b", 32'(mem_a_w_o & mem_b_v_o), 32'd0);
        chk("m_rd_v", 32'(rd_v_o), 32'(e_rdv));
        if (e_wr) begin
            chk("m_wr_addr", 32'(mem_a_addr_o), 32'(wr_addr_i));
            chk("m_wr_data", mem_a_data_o, wr_data_i);
        end
        if (e_a >= 0) chk("m_a_addr", 32'(mem_a_addr_o), 32'(aslice(e_a)));
        if (e_b >= 0) chk("m_b_addr", 32'(mem_b_addr_o), 32'(aslice(e_b)));
        for (int k = 0; k < N; k++) begin
            if (e_rdv[k] && m_pk[k]) chk("m_rd_data", dslice(k), m_pd[k]);
        end

        @(posedge clk);
        if (reset_i) begin
            m_rr     = 0;
            m_starve = 0;
            m_pv     = '0;
        end else begin
            m_pv = '0;
            if (e_wr) begin
                m_mem[wr_addr_i]   = wr_data_i;
                m_known[wr_addr_i] = 1'b1;
            end
            if (e_a >= 0) begin
                m_pv[e_a] = 1'b1;
                m_pd[e_a] = m_mem[aslice(e_a)];
                m_pk[e_a] = m_known[aslice(e_a)];
            end
            if (e_b >= 0) begin
                m_pv[e_b] = 1'b1;
                m_pd[e_b] = m_mem[aslice(e_b)];
                m_pk[e_b] = m_known[aslice(e_b)];
            end
            if (e_b >= 0) m_rr = (e_b + 1) % N;
            else if (e_a >= 0) m_rr = (e_a + 1) % N;
            if (e_a >= 0 || !any_rd) m_starve = 0;
            else if (e_wr && m_starve < MAXS) m_starve++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int k, input int a);
        rd_addr_i[k*AW +: AW] = AW'(a);
    endtask

    logic [N-1:0] seen_yumi;
    logic         seen_wy;
    logic [W-1:0] wdat;

    initial begin
        reset_i   = 1'b1;
        rd_v_i    = 4'b1111;
        rd_addr_i = '0;
        wr_v_i    = 1'b0;
        wr_addr_i = '0;
        wr_data_i = '0;

        // Reset held with every requester pending.
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            chk("rst_yumi", 32'(rd_yumi_o), 32'd0);
            chk("rst_mem_v", 32'({mem_a_v_o, mem_b_v_o}), 32'd0);
            chk("rst_rd_v", 32'(rd_v_o), 32'd0);
            tick();
        end
        reset_i = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", 32'(rd_yumi_o), 32'h3);
        tick();
        rd_v_i = '0;

        for (int i = 0; i < E; i++) begin
            wr_v_i    = 1'b1;
            wr_addr_i = AW'(i);
            wr_data_i = 32'hA5A5_0000 + 32'(i);
            @(negedge clk);
            chk("fill_wr_yumi", 32'(wr_yumi_o), 32'd1);
            tick();
        end
        wr_v_i  = 1'b0;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;

        // Dual read from a fresh pointer.
        rd_v_i = 4'b1111;
        set_addr(0, 3); set_addr(1, 5); set_addr(2, 7); set_addr(3, 9);
        @(negedge clk);
        chk("dual_c0_yumi", 32'(rd_yumi_o), 32'h3);
        tick();
        rd_v_i = 4'b1100;
        @(negedge clk);
        chk("dual_c1_yumi", 32'(rd_yumi_o), 32'hC);
        chk("dual_c0_v", 32'(rd_v_o), 32'h3);
        chk("dual_d0", dslice(0), 32'hA5A5_0003);
        chk("dual_d1", dslice(1), 32'hA5A5_0005);
        tick();
        rd_v_i = '0;
        @(negedge clk);
        chk("dual_c1_v", 32'(rd_v_o), 32'hC);
        chk("dual_d2", dslice(2), 32'hA5A5_0007);
        chk("dual_d3", dslice(3), 32'hA5A5_0009);
        tick();

        // Single requester: port b idle, pointer lands on 3.
        rd_v_i = 4'b0100;
        set_addr(2, 4);
        @(negedge clk);
        chk("single_yumi", 32'(rd_yumi_o), 32'h4);
        chk("single_b_idle", 32'(mem_b_v_o), 32'd0);
        tick();
        rd_v_i = '0;
        @(negedge clk);
        chk("single_d2", dslice(2), 32'hA5A5_0004);
        tick();

        // Wrap: 3 on port a, 0 on port b, pointer to 1.
        rd_v_i = 4'b1001;
        set_addr(3, 1); set_addr(0, 2);
        @(negedge clk);
        chk("wrap_yumi", 32'(rd_yumi_o), 32'h9);
        chk("wrap_a_addr", 32'(mem_a_addr_o), 32'd1);
        chk("wrap_b_addr", 32'(mem_b_addr_o), 32'd2);
        tick();
        rd_v_i = 4'b1111;
        set_addr(0, 12); set_addr(1, 13); set_addr(2, 14); set_addr(3, 15);
        @(negedge clk);
        chk("wrap_ptr_yumi", 32'(rd_yumi_o), 32'h6);
        chk("wrap_d3", dslice(3), 32'hA5A5_0001);
        chk("wrap_d0", dslice(0), 32'hA5A5_0002);
        tick();
        rd_v_i = 4'b1001;
        @(negedge clk);
        chk("wrap_rest_yumi", 32'(rd_yumi_o), 32'h9);
        tick();
        rd_v_i = '0;
        tick();

        // Starvation guard under continuous writes.
        wr_v_i    = 1'b1;
        wr_addr_i = 4'd10;
        wdat      = 32'h5000_0000;
        wr_data_i = wdat;
        rd_v_i    = 4'b0010;
        set_addr(1, 10);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("starve_wr_yumi", 32'(wr_yumi_o), (c == 4) ? 32'd0 : 32'd1);
            chk("starve_rd_yumi", 32'(rd_yumi_o), (c == 4) ? 32'h2 : 32'd0);
            if (c == 5) chk("starve_d1", dslice(1), 32'h5000_0003);
            tick();
            if (c == 4) rd_v_i = '0;
            else begin
                wdat      = wdat + 1;
                wr_data_i = wdat;
            end
        end
        wr_v_i = 1'b0;
        tick();

        // Read-after-write ordering.
        wr_v_i    = 1'b1;
        wr_addr_i = 4'd6;
        wr_data_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("raw_wr_yumi", 32'(wr_yumi_o), 32'd1);
        tick();
        wr_v_i = 1'b0;
        rd_v_i = 4'b0001;
        set_addr(0, 6);
        @(negedge clk);
        chk("raw_rd_yumi", 32'(rd_yumi_o), 32'h1);
        tick();
        rd_v_i = '0;
        @(negedge clk);
        chk("raw_rd_v", 32'(rd_v_o), 32'h1);
        chk("raw_d0", dslice(0), 32'hDEAD_BEEF);
        tick();

        // A grant right before reset yields no response.
        rd_v_i = 4'b0011;
        @(negedge clk);
        chk("pre_rst_yumi", 32'(rd_yumi_o), 32'h3);
        tick();
        rd_v_i  = '0;
        reset_i = 1'b1;
        @(negedge clk);
        chk("in_rst_rd_v", 32'(rd_v_o), 32'd0);
        tick();
        reset_i = 1'b0;
        @(negedge clk);
        chk("after_rst_rd_v", 32'(rd_v_o), 32'd0);
        tick();

        // Mixed traffic obeying the hold-until-yumi protocol; the model checks every cycle.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            seen_yumi = rd_yumi_o;
            seen_wy   = wr_yumi_o;
            tick();
            reset_i = (c == 200);
            for (int k = 0; k < N; k++) begin
                if (seen_yumi[k] || !rd_v_i[k]) begin
                    rd_v_i[k] = ($urandom_range(0, 2) != 0);
                    set_addr(k, int'($urandom_range(0, E - 1)));
                end
            end
            if (seen_wy || !wr_v_i) begin
                wr_v_i    = ($urandom_range(0, 1) != 0);
                wr_addr_i = AW'($urandom_range(0, E - 1));
                wr_data_i = $urandom;
            end
        end
        reset_i = 1'b0;
        rd_v_i  = '0;
        wr_v_i  = 1'b0;
        tick();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
